// File: rtl/v_pkg.sv
// Shared constants and types for the vector coprocessor front end.
// Holds the opcode filter and the instruction class decode used at issue.
package v_pkg;

  localparam logic [6:0] OPC_OPV     = 7'b1010111;
  localparam logic [6:0] OPC_LOADFP  = 7'b0000111;
  localparam logic [6:0] OPC_STOREFP = 7'b0100111;
  localparam logic [2:0] F3_OPMVV    = 3'b010;

  typedef enum logic {IQ_IDLE, IQ_EXEC} iq_state_t;
  typedef enum logic {CLS_FIXED, CLS_RED} iq_class_t;

  function automatic logic is_vec(input logic [31:0] w);
    return (w[6:0] == OPC_OPV) || (w[6:0] == OPC_LOADFP) || (w[6:0] == OPC_STOREFP);
  endfunction

  // Reductions are OPMVV with funct6[5:3] == 0; they wait on the reduction unit.
  function automatic iq_class_t classify(input logic [31:0] w);
    return ((w[6:0] == OPC_OPV) && (w[14:12] == F3_OPMVV) && (w[31:29] == 3'b000))
           ? CLS_RED : CLS_FIXED;
  endfunction

endpackage

// File: rtl/v_iq_fifo.sv
// Generic synchronous FIFO with separate occupancy counter and synchronous clear.
// Push when full and pop when empty are ignored.
module v_iq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= AW'(wptr_q + 1'b1);
      if (do_pop)  rptr_q <= AW'(rptr_q + 1'b1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/v_issue_queue.sv
// Issue queue feeding the vector coprocessor decoder: filters non-vector words,
// buffers them, and holds each on instr_out for its execute window.
module v_issue_queue
  import v_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int EXEC_CYCLES = 1,
  parameter int RED_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       red_done,
  output logic [31:0]                instr_out,
  output logic                       issue_valid,
  output logic                       busy,
  output logic                       illegal,
  output logic                       timeout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CMAX = (EXEC_CYCLES > RED_TIMEOUT) ? EXEC_CYCLES : RED_TIMEOUT;
  localparam int CNTW = $clog2(CMAX + 1);

  iq_state_t   state_q, state_d;
  iq_class_t   cls_q, cls_d;
  logic [31:0] instr_q, instr_d;
  logic [CNTW-1:0] cyc_q, cyc_d;
  logic        issue_q, issue_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;

  logic        accept, legal, push, pop, last, full, empty;
  logic [31:0] head;

  assign accept = in_valid && in_ready;
  assign legal  = is_vec(in_instr);
  assign push   = accept && legal && !flush;

  v_iq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_instr),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready    = !full;
  assign instr_out   = instr_q;
  assign issue_valid = issue_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign busy        = (state_q != IQ_IDLE) || !empty;

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    instr_d   = instr_q;
    cyc_d     = cyc_q;
    issue_d   = 1'b0;
    timeout_d = 1'b0;
    illegal_d = accept && !legal && !flush;
    pop       = 1'b0;
    last      = 1'b0;

    if (state_q == IQ_EXEC) begin
      if (cls_q == CLS_FIXED) begin
        last = (cyc_q == CNTW'(EXEC_CYCLES - 1));
      end else begin
        last      = red_done || (cyc_q == CNTW'(RED_TIMEOUT - 1));
        timeout_d = !red_done && (cyc_q == CNTW'(RED_TIMEOUT - 1));
      end
    end

    // A retiring instruction hands over to the head in the same cycle.
    if ((state_q == IQ_IDLE || last) && !empty) begin
      pop     = 1'b1;
      state_d = IQ_EXEC;
      instr_d = head;
      cls_d   = classify(head);
      cyc_d   = '0;
      issue_d = 1'b1;
    end else if (state_q == IQ_EXEC && last) begin
      state_d = IQ_IDLE;
      instr_d = '0;
      cls_d   = CLS_FIXED;
      cyc_d   = '0;
    end else if (state_q == IQ_EXEC) begin
      cyc_d = CNTW'(cyc_q + 1'b1);
    end

    if (flush) begin
      state_d   = IQ_IDLE;
      instr_d   = '0;
      cls_d     = CLS_FIXED;
      cyc_d     = '0;
      issue_d   = 1'b0;
      timeout_d = 1'b0;
      illegal_d = 1'b0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IQ_IDLE;
      cls_q     <= CLS_FIXED;
      instr_q   <= '0;
      cyc_q     <= '0;
      issue_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instr_q   <= instr_d;
      cyc_q     <= cyc_d;
      issue_q   <= issue_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_v_issue_queue.sv
// Directed bench for v_issue_queue with default parameters (DEPTH=4, EXEC_CYCLES=1, RED_TIMEOUT=64).
module tb_v_issue_queue;
  import v_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        red_done = 1'b0;
  logic [31:0] instr_out;
  logic        issue_valid, busy, illegal, timeout;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] VADD = 32'h022081D7;
  localparam logic [31:0] VRED = 32'h0220A1D7;
  localparam logic [31:0] ADD  = 32'h00000033;

  v_issue_queue dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .red_done   (red_done),
    .instr_out  (instr_out),
    .issue_valid(issue_valid),
    .busy       (busy),
    .illegal    (illegal),
    .timeout    (timeout),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one word and let its issue start on the following edge.
  task automatic issue_one(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] w [5];
    int held;
    w[0] = 32'h022081D7; w[1] = 32'h02208257; w[2] = 32'h022082D7;
    w[3] = 32'h02208357; w[4] = 32'h022083D7;

    // Reset values
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_issue", 32'(issue_valid), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    nrst = 1'b1;
    step();
    chk("rst_ready", 32'(in_ready), 1);

    // Single vadd: count, then issue, then idle
    in_valid = 1'b1; in_instr = VADD;
    step();
    in_valid = 1'b0;
    chk("t1_count", 32'(count), 1);
    chk("t1_instr_pre", instr_out, 0);
    step();
    chk("t1_instr", instr_out, VADD);
    chk("t1_issue", 32'(issue_valid), 1);
    step();
    chk("t1_idle_instr", instr_out, 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_issue", 32'(issue_valid), 0);

    // Fill FIFO behind a held reduction, then drain back-to-back
    issue_one(VRED);
    chk("t2_red_instr", instr_out, VRED);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = w[i];
      step();
    end
    chk("t2_full_count", 32'(count), 4);
    chk("t2_full_ready", 32'(in_ready), 0);
    in_instr = w[4];
    step();
    in_valid = 1'b0;
    chk("t2_5th_count", 32'(count), 4);
    chk("t2_hold_red", instr_out, VRED);
    red_done = 1'b1;
    step();
    red_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_drain_instr%0d", i), instr_out, w[i]);
      chk($sformatf("t2_drain_issue%0d", i), 32'(issue_valid), 1);
      chk($sformatf("t2_drain_count%0d", i), 32'(count), 32'(3 - i));
      step();
    end
    chk("t2_end_instr", instr_out, 0);
    chk("t2_end_busy", 32'(busy), 0);

    // Reduction done 10 cycles after issue: held for 11 cycles
    issue_one(VRED);
    chk("t3_issue", 32'(issue_valid), 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t3_hold%0d", k), instr_out, VRED);
    end
    red_done = 1'b1;
    step();
    red_done = 1'b0;
    chk("t3_retire_instr", instr_out, 0);
    chk("t3_retire_timeout", 32'(timeout), 0);

    // Reduction with no done: forced retire after RED_TIMEOUT cycles
    issue_one(VRED);
    held = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (instr_out == VRED) held++;
      else break;
    end
    chk("t4_held_cycles", 32'(held), 64);
    chk("t4_timeout", 32'(timeout), 1);
    chk("t4_instr", instr_out, 0);
    step();
    chk("t4_timeout_pulse", 32'(timeout), 0);

    // Non-vector word: consumed, not queued, illegal pulse
    in_valid = 1'b1; in_instr = ADD;
    chk("t5_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_illegal", 32'(illegal), 1);
    chk("t5_instr", instr_out, 0);
    step();
    chk("t5_illegal_pulse", 32'(illegal), 0);
    chk("t5_instr2", instr_out, 0);

    // Flush with three queued, one executing, simultaneous push and red_done
    issue_one(VRED);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = w[i];
      step();
    end
    chk("t6_pre_count", 32'(count), 3);
    in_instr = w[3]; flush = 1'b1; red_done = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0; red_done = 1'b0;
    chk("t6_count", 32'(count), 0);
    chk("t6_instr", instr_out, 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_issue", 32'(issue_valid), 0);
    chk("t6_illegal", 32'(illegal), 0);
    step();
    chk("t6_after_count", 32'(count), 0);
    chk("t6_after_issue", 32'(issue_valid), 0);
    chk("t6_after_instr", instr_out, 0);

    // Asynchronous reset mid-reduction with two queued
    issue_one(VRED);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = w[i];
      step();
    end
    in_valid = 1'b0;
    chk("t7_pre_count", 32'(count), 2);
    #2 nrst = 1'b0;
    #1;
    chk("t7_rst_count", 32'(count), 0);
    chk("t7_rst_instr", instr_out, 0);
    chk("t7_rst_busy", 32'(busy), 0);
    #1 nrst = 1'b1;
    step();
    chk("t7_ready", 32'(in_ready), 1);
    issue_one(w[2]);
    chk("t7_post_instr", instr_out, w[2]);
    chk("t7_post_issue", 32'(issue_valid), 1);
    step();
    chk("t7_post_idle", instr_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
